regfile_wb_arbiter: RTL and testbench

- Shares the single write port of the 16x16 register file between two writeback requesters: A (ALU writeback) and B (load-unit writeback).
- Each requester has a small FIFO behind a valid/ready handshake.
- A round-robin arbiter drains the FIFOs one write per cycle onto registered RegWrite/WriteReg/WriteData outputs.
- Sits between the execute/memory stages and the register file write port.

---
 rtl/regfile_wb_arbiter.sv | 101 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester writeback FIFOs with round-robin arbitration onto one RF write port
// Optional macro RFARB_R0_DISCARD_EN: granted entries targeting register 0 produce no rf_we pulse.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic [AW-1:0]               a_reg,
  input  logic [DW-1:0]               a_data,
  input  logic                        b_valid,
  output logic                        b_ready,
  input  logic [AW-1:0]               b_reg,
  input  logic [DW-1:0]               b_data,
  output logic                        rf_we,
  output logic [AW-1:0]               rf_waddr,
  output logic [DW-1:0]               rf_wdata,
  output logic [$clog2(2*DEPTH):0]    pending,
  output logic [15:0]                 conflict_cnt
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int PNW = $clog2(2*DEPTH) + 1;
  localparam int EW  = AW + DW;

  logic [EW-1:0] r_a_mem [DEPTH];
  logic [EW-1:0] r_b_mem [DEPTH];
  logic [PW-1:0] r_a_wptr, r_a_rptr, r_b_wptr, r_b_rptr;
  logic [CW-1:0] r_a_cnt, r_b_cnt;
  logic          r_last_b;

  logic          w_a_push, w_b_push, w_a_ne, w_b_ne;
  logic          w_grant_a, w_grant_b, w_grant, w_we_nxt;
  logic [EW-1:0] w_sel;
  logic [CW-1:0] w_a_cnt_nxt, w_b_cnt_nxt;

  // Ready looks only at occupancy, so a same-cycle pop never frees a full FIFO.
  assign a_ready  = (r_a_cnt != CW'(DEPTH));
  assign b_ready  = (r_b_cnt != CW'(DEPTH));
  assign w_a_push = a_valid && a_ready;
  assign w_b_push = b_valid && b_ready;
  assign w_a_ne   = (r_a_cnt != '0);
  assign w_b_ne   = (r_b_cnt != '0);

  assign w_grant_a = w_a_ne && (!w_b_ne || r_last_b);
  assign w_grant_b = w_b_ne && !w_grant_a;
  assign w_grant   = w_grant_a || w_grant_b;
  assign w_sel     = w_grant_a ? r_a_mem[r_a_rptr] : r_b_mem[r_b_rptr];

`ifdef RFARB_R0_DISCARD_EN
  assign w_we_nxt = w_grant && (w_sel[EW-1:DW] != '0);
`else
  assign w_we_nxt = w_grant;
`endif

  assign w_a_cnt_nxt = r_a_cnt + CW'(w_a_push) - CW'(w_grant_a);
  assign w_b_cnt_nxt = r_b_cnt + CW'(w_b_push) - CW'(w_grant_b);

  always_ff @(posedge clk) begin
    if (w_a_push) r_a_mem[r_a_wptr] <= {a_reg, a_data};
    if (w_b_push) r_b_mem[r_b_wptr] <= {b_reg, b_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_wptr     <= '0;
      r_a_rptr     <= '0;
      r_b_wptr     <= '0;
      r_b_rptr     <= '0;
      r_a_cnt      <= '0;
      r_b_cnt      <= '0;
      r_last_b     <= 1'b1;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      pending      <= '0;
      conflict_cnt <= '0;
    end else begin
      if (w_a_push)  r_a_wptr <= r_a_wptr + PW'(1);
      if (w_b_push)  r_b_wptr <= r_b_wptr + PW'(1);
      if (w_grant_a) r_a_rptr <= r_a_rptr + PW'(1);
      if (w_grant_b) r_b_rptr <= r_b_rptr + PW'(1);
      r_a_cnt <= w_a_cnt_nxt;
      r_b_cnt <= w_b_cnt_nxt;
      if (w_grant) r_last_b <= w_grant_b;
      rf_we <= w_we_nxt;
      if (w_we_nxt) begin
        rf_waddr <= w_sel[EW-1:DW];
        rf_wdata <= w_sel[DW-1:0];
      end
      pending <= PNW'(w_a_cnt_nxt) + PNW'(w_b_cnt_nxt);
      if (w_a_ne && w_b_ne && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int PNW   = $clog2(2*DEPTH) + 1;

  typedef logic [AW+DW-1:0] ent_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           a_valid = 1'b0, b_valid = 1'b0;
  logic           a_ready, b_ready;
  logic [AW-1:0]  a_reg = '0, b_reg = '0;
  logic [DW-1:0]  a_data = '0, b_data = '0;
  logic           rf_we;
  logic [AW-1:0]  rf_waddr;
  logic [DW-1:0]  rf_wdata;
  logic [PNW-1:0] pending;
  logic [15:0]    conflict_cnt;

  int n_vec = 0;
  int n_err = 0;

  ent_t          qa[$], qb[$], wlog[$];
  logic          m_last_b, m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int            m_conf;
  bit            a_acc, b_acc;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending(pending), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_last_b = 1'b1;
    m_we     = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
    m_conf   = 0;
  endtask

  // One clock edge of the reference: pops use pre-edge contents, pushes land afterwards.
  task automatic model_edge();
    ent_t e;
    bit ane, bne, ga, gb;
    a_acc = a_valid && (qa.size() < DEPTH);
    b_acc = b_valid && (qb.size() < DEPTH);
    ane = qa.size() != 0;
    bne = qb.size() != 0;
    ga  = ane && (!bne || m_last_b);
    gb  = bne && !ga;
    if (ane && bne && m_conf < 65535) m_conf++;
    m_we = 1'b0;
    if (ga || gb) begin
      if (ga) begin e = qa.pop_front(); m_last_b = 1'b0; end
      else    begin e = qb.pop_front(); m_last_b = 1'b1; end
`ifdef RFARB_R0_DISCARD_EN
      if (e[AW+DW-1:DW] != '0) begin
`else
      begin
`endif
        m_we    = 1'b1;
        m_waddr = e[AW+DW-1:DW];
        m_wdata = e[DW-1:0];
      end
    end
    if (a_acc) qa.push_back({a_reg, a_data});
    if (b_acc) qb.push_back({b_reg, b_data});
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic step();
    logic exp_ar, exp_br;
    exp_ar = (qa.size() < DEPTH);
    exp_br = (qb.size() < DEPTH);
    n_vec++;
    if (a_ready !== exp_ar) begin n_err++; $display("FAIL a_ready: got %b expected %b", a_ready, exp_ar); end
    n_vec++;
    if (b_ready !== exp_br) begin n_err++; $display("FAIL b_ready: got %b expected %b", b_ready, exp_br); end
    model_edge();
    @(posedge clk);
    #1;
    n_vec++;
    if (rf_we !== m_we) begin n_err++; $display("FAIL rf_we: got %b expected %b", rf_we, m_we); end
    n_vec++;
    if (rf_waddr !== m_waddr) begin n_err++; $display("FAIL rf_waddr: got %0d expected %0d", rf_waddr, m_waddr); end
    n_vec++;
    if (rf_wdata !== m_wdata) begin n_err++; $display("FAIL rf_wdata: got %h expected %h", rf_wdata, m_wdata); end
    n_vec++;
    if (pending !== PNW'(qa.size() + qb.size())) begin
      n_err++; $display("FAIL pending: got %0d expected %0d", pending, qa.size() + qb.size());
    end
    n_vec++;
    if (conflict_cnt !== 16'(m_conf)) begin
      n_err++; $display("FAIL conflict_cnt: got %0d expected %0d", conflict_cnt, m_conf);
    end
    if (rf_we === 1'b1) wlog.push_back({rf_waddr, rf_wdata});
    @(negedge clk);
  endtask

  task automatic do_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    wlog.delete();
  endtask

  task automatic check_reset_values(input string tag);
    n_vec++;
    if (rf_we !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b1 || pending !== '0 || conflict_cnt !== '0) begin
      n_err++;
      $display("FAIL %s: got we=%b ar=%b br=%b pend=%0d conf=%0d expected 0 1 1 0 0",
               tag, rf_we, a_ready, b_ready, pending, conflict_cnt);
    end
  endtask

  task automatic test_reset();
    #2;
    check_reset_values("reset_state");
    n_vec++;
    if (rf_waddr !== '0 || rf_wdata !== '0) begin
      n_err++; $display("FAIL reset_addr_data: got %0d %h expected 0 0", rf_waddr, rf_wdata);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step();
    step();
  endtask

  task automatic test_single_a();
    a_valid = 1'b1; a_reg = 4'd3; a_data = 16'hBEEF;
    step();
    a_valid = 1'b0;
    step();
    n_vec++;
    if (rf_we !== 1'b1 || rf_waddr !== 4'd3 || rf_wdata !== 16'hBEEF) begin
      n_err++; $display("FAIL single_a_write: got we=%b addr=%0d data=%h expected 1 3 beef", rf_we, rf_waddr, rf_wdata);
    end
    step();
    n_vec++;
    if (rf_we !== 1'b0) begin n_err++; $display("FAIL single_a_drop: got we=%b expected 0", rf_we); end
  endtask

  task automatic test_streams();
    ent_t exp_w[4];
    do_reset();
    exp_w = '{{4'd1, 16'h0001}, {4'd5, 16'h0005}, {4'd2, 16'h0002}, {4'd6, 16'h0006}};
    a_valid = 1'b1; a_reg = 4'd1; a_data = 16'h0001;
    b_valid = 1'b1; b_reg = 4'd5; b_data = 16'h0005;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    a_valid = 1'b1; a_reg = 4'd2; a_data = 16'h0002;
    b_valid = 1'b1; b_reg = 4'd6; b_data = 16'h0006;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_vec++;
    if (wlog.size() != 4) begin
      n_err++; $display("FAIL streams_count: got %0d writes expected 4", wlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (wlog[i] !== exp_w[i]) begin
          n_err++; $display("FAIL streams_order[%0d]: got %h expected %h", i, wlog[i], exp_w[i]);
        end
      end
    end
    n_vec++;
    if (conflict_cnt !== 16'd2) begin n_err++; $display("FAIL streams_conflict: got %0d expected 2", conflict_cnt); end
  endtask

  task automatic test_backpressure();
    int   b_idx;
    bit   saw_full;
    ent_t bw[$];
    do_reset();
    b_idx = 0;
    saw_full = 1'b0;
    a_reg = 4'd1; a_data = 16'hA000;
    for (int cyc = 0; cyc < 40 && b_idx < 3; cyc++) begin
      a_valid = 1'b1;
      b_valid = 1'b1; b_reg = 4'(8 + b_idx); b_data = 16'(16'hB001 + b_idx);
      if (!b_ready) saw_full = 1'b1;
      step();
      if (a_acc) a_data = a_data + 16'd1;
      if (b_acc) b_idx++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    n_vec++;
    if (b_idx != 3) begin n_err++; $display("FAIL bp_accepted: got %0d expected 3", b_idx); end
    n_vec++;
    if (!saw_full) begin n_err++; $display("FAIL bp_ready_low: got 0 expected 1"); end
    foreach (wlog[i]) if (wlog[i][AW+DW-1:DW] >= 4'd8) bw.push_back(wlog[i]);
    n_vec++;
    if (bw.size() != 3) begin
      n_err++; $display("FAIL bp_b_count: got %0d expected 3", bw.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (bw[i] !== ent_t'({4'(8 + i), 16'(16'hB001 + i)})) begin
          n_err++; $display("FAIL bp_order[%0d]: got %h expected %h", i, bw[i], {4'(8 + i), 16'(16'hB001 + i)});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_valid = 1'b1; a_reg = 4'd7; a_data = 16'h1111;
    b_valid = 1'b1; b_reg = 4'd9; b_data = 16'h2222;
    step();
    a_data = 16'h3333; b_data = 16'h4444;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("reset_mid");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_mid_quiet: got we=%b expected 0", rf_we); end
    end
    test_single_a();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if (!a_valid || a_acc) begin
        a_valid = 1'($urandom_range(0, 1));
        a_reg   = 4'($urandom_range(0, 15));
        a_data  = 16'($urandom);
      end
      if (!b_valid || b_acc) begin
        b_valid = 1'($urandom_range(0, 1));
        b_reg   = 4'($urandom_range(0, 15));
        b_data  = 16'($urandom);
      end
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_r0();
    do_reset();
    a_valid = 1'b1; a_reg = 4'd0; a_data = 16'h1234;
    step();
    a_reg = 4'd4; a_data = 16'h5678;
    step();
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
`ifdef RFARB_R0_DISCARD_EN
    n_vec++;
    if (wlog.size() != 1 || wlog[0] !== ent_t'({4'd4, 16'h5678})) begin
      n_err++; $display("FAIL r0_discard: got %0d writes expected 1 to r4", wlog.size());
    end
`else
    n_vec++;
    if (wlog.size() != 2 || wlog[0] !== ent_t'({4'd0, 16'h1234}) || wlog[1] !== ent_t'({4'd4, 16'h5678})) begin
      n_err++; $display("FAIL r0_write: got %0d writes expected 2 to r0 then r4", wlog.size());
    end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_a();
    test_streams();
    test_backpressure();
    test_reset_mid();
    test_r0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
